// File: rtl/sntc_ldpc_pkg.sv
// Shared definitions for the LDPC codeword path: code geometry defaults,
// beat-count helper and the serializer state encoding.
package sntc_ldpc_pkg;

    // Codeword length, parity length of the rate-1/2 code, and line-side beat width
    localparam int NN_DEF = 'h000d0;
    localparam int MM_DEF = 104;
    localparam int W_DEF  = 16;

    // Number of W-bit beats needed to carry an nn-bit codeword
    function automatic int nbeats(input int nn, input int w);
        return (nn + w - 1) / w;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/sntc_ldpc_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sntc_ldpc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc until all-ones; clear wins over increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sntc_ldpc_cword_serializer.sv
// Codeword serializer: takes a full codeword through a one-entry hold
// buffer and streams it LSB-first as W-bit beats with valid/ready/last.
// The hold buffer is refilled while the previous codeword is still being
// sent, so back-to-back codewords stream without bubbles.
module sntc_ldpc_cword_serializer
    import sntc_ldpc_pkg::*;
#(
    parameter int NN    = NN_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [NN-1:0]    cw_in,
    input  logic             cw_ok,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_bad,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int NBEATS = nbeats(NN, W);
    localparam int SR_W   = NBEATS * W;
    localparam int BC_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NBEATS - 1);

    state_t          state;
    logic            hold_full;
    logic            hold_ok;
    logic [SR_W-1:0] hold_data;
    logic [SR_W-1:0] shift_reg;
    logic            bad_r;
    logic [BC_W-1:0] beat_cnt;

    logic accept;
    logic fire;
    logic is_last;
    logic drain;

    // in_ready comes straight from the hold-full flop, so out_ready never
    // reaches it combinationally
    assign in_ready  = !hold_full;
    assign accept    = in_valid && !hold_full;
    assign fire      = (state == SEND) && out_ready;
    assign is_last   = (beat_cnt == LAST_BEAT);
    assign drain     = hold_full && ((state == IDLE) || (fire && is_last));

    assign out_valid = (state == SEND);
    assign out_data  = shift_reg[W-1:0];
    assign out_last  = (state == SEND) && is_last;
    assign out_bad   = (state == SEND) && bad_r;

    // Hold-buffer occupancy: set on accept, cleared when moved into the shifter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_full <= 1'b0;
        end else if (clr) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    // Hold-buffer payload; zero-extended so a short final beat is padded
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= SR_W'(cw_in);
            hold_ok   <= cw_ok;
        end
    end

    // Serializer FSM: load from hold, shift one beat per accepted transfer,
    // reload directly on the last beat when another codeword is waiting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            shift_reg <= '0;
            bad_r     <= 1'b0;
            beat_cnt  <= '0;
        end else if (clr) begin
            state     <= IDLE;
            shift_reg <= '0;
            bad_r     <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift_reg <= hold_data;
                        bad_r     <= hold_ok ? 1'b0 : 1'b1;
                        beat_cnt  <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (!is_last) begin
                            shift_reg <= shift_reg >> W;
                            beat_cnt  <= beat_cnt + BC_W'(1);
                        end else if (hold_full) begin
                            shift_reg <= hold_data;
                            bad_r     <= hold_ok ? 1'b0 : 1'b1;
                            beat_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sntc_ldpc_sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .inc   (accept && !cw_ok),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_sntc_ldpc_cword_serializer.sv
// Bench for the codeword serializer: reference queue model of expected beats,
// table of single-codeword scenarios, directed corner sequences, random soak.
module tb_sntc_ldpc_cword_serializer;

    localparam int NN = 208;
    localparam int W  = 16;
    localparam int NB = (NN + W - 1) / W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic [NN-1:0] cw_in = '0;
    logic          cw_ok = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          out_bad;
    logic [15:0]   err_cnt;

    logic          in_ready2;
    logic [W-1:0]  out_data2;
    logic          out_valid2;
    logic          out_last2;
    logic          out_bad2;
    logic [1:0]    err_cnt2;

    int checks = 0;
    int errors = 0;

    sntc_ldpc_cword_serializer #(.NN(NN), .W(W), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .cw_in(cw_in), .cw_ok(cw_ok),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_bad(out_bad), .err_cnt(err_cnt)
    );

    sntc_ldpc_cword_serializer #(.NN(NN), .W(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .clr(clr), .cw_in(cw_in), .cw_ok(cw_ok),
        .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_last(out_last2),
        .out_bad(out_bad2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         bad;
    } beat_t;

    beat_t        q[$];
    int           m_err = 0;
    int           m_err2 = 0;
    logic         stall_v = 1'b0;
    logic [W+1:0] held;

    // Everything sampled at the falling edge is exactly what the next rising edge acts on
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            m_err   = 0;
            m_err2  = 0;
            stall_v = 1'b0;
        end else begin
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
            chk("err_cnt_sat", 64'(err_cnt2), 64'(m_err2));
            if (stall_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_stable", 64'({out_data, out_last, out_bad}), 64'(held));
            end
            stall_v = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat_data", 64'(out_data), 64'(e.data));
                    chk("beat_last", 64'(out_last), 64'(e.last));
                    chk("beat_bad", 64'(out_bad), 64'(e.bad));
                end
            end else if (out_valid) begin
                stall_v = 1'b1;
                held    = {out_data, out_last, out_bad};
            end
            if (clr) begin
                q.delete();
                m_err   = 0;
                m_err2  = 0;
                stall_v = 1'b0;
            end else if (in_valid && in_ready) begin
                for (int k = 0; k < NB; k++) begin
                    beat_t b;
                    logic [NB*W-1:0] padded;
                    padded = (NB*W)'(cw_in);
                    b.data = padded[k*W +: W];
                    b.last = (k == NB - 1);
                    b.bad  = !cw_ok;
                    q.push_back(b);
                end
                if (!cw_ok) begin
                    if (m_err < 65535) m_err++;
                    if (m_err2 < 3) m_err2++;
                end
            end
        end
    end

    function automatic logic [NN-1:0] rand_cw();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom();
        return r[NN-1:0];
    endfunction

    task automatic do_clr();
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic accept_one(input logic [NN-1:0] cw, input logic ok, output logic got);
        cw_in = cw; cw_ok = ok; in_valid = 1'b1; got = 1'b0;
        for (int g = 0; g < 60 && !got; g++) begin
            @(negedge clk); got = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- table of single-codeword scenarios ----------------
    typedef struct {
        logic ok;
        int   mode;        // 0 ready high, 1 toggle starting low, 2 low for 5 valid cycles
        int   exp_cycles;  // valid cycles from first beat through the last transfer
        logic exp_bad;
        int   exp_err;
    } vec_t;

    vec_t vecs[5];

    logic [NN-1:0] cws[5];
    logic          oks[5];
    logic [W-1:0]  beats[16];
    logic          got;
    logic          done;
    logic          first_bad;
    int            cyc, nb, nlast, last_idx, n, guard, run, g2, vcount;
    logic          acc;

    initial begin
        vecs[0] = '{ok: 1'b1, mode: 0, exp_cycles: 13, exp_bad: 1'b0, exp_err: 0};
        vecs[1] = '{ok: 1'b0, mode: 0, exp_cycles: 13, exp_bad: 1'b1, exp_err: 1};
        vecs[2] = '{ok: 1'b1, mode: 1, exp_cycles: 26, exp_bad: 1'b0, exp_err: 0};
        vecs[3] = '{ok: 1'b0, mode: 1, exp_cycles: 26, exp_bad: 1'b1, exp_err: 1};
        vecs[4] = '{ok: 1'b1, mode: 2, exp_cycles: 18, exp_bad: 1'b0, exp_err: 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_bad", 64'(out_bad), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Pattern codeword: beat k = {k,k}
        for (int k = 0; k < NB; k++) cw_in[k*W +: W] = {8'(k), 8'(k)};
        out_ready = 1'b1;
        @(posedge clk); #1;
        accept_one(cw_in, 1'b1, got);
        chk("pat_lat1", 64'(out_valid), 64'd0);
        nb = 0; nlast = 0; last_idx = -1; done = 1'b0;
        for (int g = 0; g < 40 && !done; g++) begin
            @(negedge clk);
            if (out_valid && out_ready && nb < 16) begin
                if (nb == 0) chk("pat_first_valid_at_2", 64'(g), 64'd1);
                beats[nb] = out_data;
                if (out_last) begin nlast++; last_idx = nb; done = 1'b1; end
                nb++;
            end
        end
        chk("pat_nbeats", 64'(nb), 64'd13);
        chk("pat_beat0", 64'(beats[0]), 64'h0000);
        chk("pat_beat7", 64'(beats[7]), 64'h0707);
        chk("pat_beat12", 64'(beats[12]), 64'h0C0C);
        chk("pat_last_idx", 64'(last_idx), 64'd12);
        chk("pat_nlast", 64'(nlast), 64'd1);

        // Table-driven single codewords under different ready patterns
        for (int v = 0; v < 5; v++) begin
            do_clr();
            accept_one(rand_cw(), vecs[v].ok, got);
            chk("tbl_lat_edge1", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk("tbl_lat_edge2", 64'(out_valid), 64'd1);
            cyc = 0; done = 1'b0; first_bad = 1'b0;
            while (!done && cyc < 100 && out_valid) begin
                cyc++;
                case (vecs[v].mode)
                    1:       out_ready = (cyc % 2 == 0);
                    2:       out_ready = (cyc > 5);
                    default: out_ready = 1'b1;
                endcase
                if (cyc == 1) first_bad = out_bad;
                @(negedge clk);
                if (out_valid && out_ready && out_last) done = 1'b1;
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
            chk("tbl_cycles", 64'(cyc), 64'(vecs[v].exp_cycles));
            chk("tbl_first_bad", 64'(first_bad), 64'(vecs[v].exp_bad));
            chk("tbl_err", 64'(err_cnt), 64'(vecs[v].exp_err));
            chk("tbl_idle_after", 64'(out_valid), 64'd0);
        end

        // Three codewords back to back, codewords 1 and 3 bad
        do_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin cws[i] = rand_cw(); oks[i] = (i == 1); end
        fork
            begin
                n = 0; guard = 0;
                cw_in = cws[0]; cw_ok = oks[0]; in_valid = 1'b1;
                while (n < 3 && guard < 200) begin
                    @(negedge clk); acc = in_ready;
                    @(posedge clk); #1; guard++;
                    if (acc) begin
                        n++;
                        if (n == 2) chk("in_ready_after_2nd", 64'(in_ready), 64'd0);
                        if (n < 3) begin cw_in = cws[n]; cw_ok = oks[n]; end
                    end
                end
                in_valid = 1'b0;
                chk("three_accepts", 64'(n), 64'd3);
            end
            begin
                g2 = 0;
                @(negedge clk);
                while (!out_valid && g2 < 20) begin @(negedge clk); g2++; end
                run = 0;
                while (out_valid && run < 100) begin run++; @(negedge clk); end
                chk("zero_bubble_run", 64'(run), 64'd39);
            end
        join
        chk("three_err_cnt", 64'(err_cnt), 64'd2);

        // clr at beat 5 with a second codeword waiting in hold
        do_clr();
        accept_one(rand_cw(), 1'b0, got);
        accept_one(rand_cw(), 1'b1, got);
        out_ready = 1'b1;
        n = 0;
        for (int g = 0; g < 40 && n < 5; g++) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        @(posedge clk); #1;
        chk("clr_pre_hold_full", 64'(in_ready), 64'd0);
        chk("clr_pre_err", 64'(err_cnt), 64'd1);
        out_ready = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);
        out_ready = 1'b1;
        vcount = 0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("clr_discarded", 64'(vcount), 64'd0);

        // Saturation of a 2-bit counter with five bad codewords
        do_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept_one(rand_cw(), 1'b0, got);
            chk("sat_cnt2", 64'(err_cnt2), 64'((i + 1 > 3) ? 3 : i + 1));
            chk("sat_cnt16", 64'(err_cnt), 64'(i + 1));
        end
        repeat (80) @(posedge clk);
        #1;
        chk("sat_final", 64'(err_cnt2), 64'd3);

        // Asynchronous reset in the middle of a codeword
        do_clr();
        out_ready = 1'b1;
        accept_one(rand_cw(), 1'b0, got);
        repeat (4) @(posedge clk);
        #3;
        chk("arst_pre_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_last", 64'(out_last), 64'd0);
        chk("arst_out_bad", 64'(out_bad), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        #2 rstn = 1'b1;

        // Random soak against the queue model
        @(posedge clk); #1;
        for (int c = 0; c < 1200; c++) begin
            cw_in     = rand_cw();
            cw_ok     = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 100 && (q.size() != 0 || out_valid); g++) @(posedge clk);
        #1;
        chk("rand_drained", 64'(q.size()), 64'd0);
        chk("rand_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
